k005297_bubble_page_tx: RTL and testbench

Bit-serial transmitter for bubble page data, the write-direction counterpart of the controller's bubble read path. It frames one page as SYNC word, PAGE_BYTES data bytes, CRC-16 and a gap, and clocks it out MSB-first on one serial line paced by the controller's clock enable. Bytes come from the controller's page buffer over a request/valid handshake. It sits between the RAM-side DMA logic and the bubble write driver.

---
 rtl/k005297_bubble_page_tx_if.sv | 14 +
 rtl/k005297_bubble_page_tx.sv | 163 ++++++++++++++++
 tb/tb_k005297_bubble_page_tx.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/k005297_bubble_page_tx_if.sv
// k005297_bubble_page_tx_if: byte-feed handshake, control and serial output of the bubble page transmitter.
interface k005297_bubble_page_tx_if;
    logic       cen_n;
    logic       start;
    logic       bvalid;
    logic [7:0] bdata;
    logic       breq;
    logic       bdout;
    logic       busy;
    logic       done;
    logic       underrun;
    modport master (output cen_n, start, bvalid, bdata, input breq, bdout, busy, done, underrun);
    modport slave (input cen_n, start, bvalid, bdata, output breq, bdout, busy, done, underrun);
endinterface

// File: rtl/k005297_bubble_page_tx.sv
// k005297_bubble_page_tx: frames SYNC, page bytes, optional CRC-16 and a zero gap onto one MSB-first serial line.
// Define K005297_BUBBLE_TX_CRC_EN to include the CRC-16/CCITT trailer after the data bytes.
module k005297_bubble_page_tx #(
    parameter int          PAGE_BYTES = 64,
    parameter int          BIT_DIV    = 4,
    parameter logic [15:0] SYNC_WORD  = 16'hF0A5,
    parameter int          GAP_BITS   = 8
) (
    input logic clk,
    input logic rst_n,
    k005297_bubble_page_tx_if.slave bus
);
    localparam int DATA_BITS = 8 * PAGE_BYTES;
    typedef enum logic [2:0] {
        IDLE, SYNC, DATA,
`ifdef K005297_BUBBLE_TX_CRC_EN
        CRC,
`endif
        GAP
    } state_t;
    state_t      state, state_d;
    logic [3:0]  div, div_d;
    logic [10:0] cnt, cnt_d, len;
    logic [15:0] sh, sh_d;
    logic [7:0]  hold, hold_d, nb;
    logic        hok, hok_d, req, req_d, dout, dout_d, fin, fin_d, und, und_d;
    logic        take, wrap, last, load;
`ifdef K005297_BUBBLE_TX_CRC_EN
    logic [15:0] crc, crc_d, crc_n;
`endif
    assign bus.breq     = req;
    assign bus.bdout    = dout;
    assign bus.busy     = state != IDLE;
    assign bus.done     = fin;
    assign bus.underrun = und;
    always_comb begin
        state_d = state;
        div_d   = div;
        cnt_d   = cnt;
        sh_d    = sh;
        hold_d  = hold;
        hok_d   = hok;
        req_d   = req;
        dout_d  = dout;
        und_d   = und;
        fin_d   = 1'b0;
        take    = req && bus.bvalid;
        nb      = take ? bus.bdata : (hok ? hold : 8'h00);
        wrap    = div == 4'(BIT_DIV - 1);
`ifdef K005297_BUBBLE_TX_CRC_EN
        crc_d   = crc;
        crc_n   = {crc[14:0], 1'b0} ^ ((crc[15] ^ sh[15]) ? 16'h1021 : 16'h0000);
        len     = state == SYNC ? 11'd16 : state == DATA ? 11'(DATA_BITS) : state == CRC ? 11'd16 : 11'(GAP_BITS);
`else
        len     = state == SYNC ? 11'd16 : state == DATA ? 11'(DATA_BITS) : 11'(GAP_BITS);
`endif
        last    = cnt == len - 11'd1;
        load    = (state == SYNC && last) || (state == DATA && !last && cnt[2:0] == 3'd7);
        if (!bus.cen_n) begin
            if (take) begin
                hold_d = bus.bdata;
                hok_d  = 1'b1;
                req_d  = 1'b0;
            end
            if (state == IDLE) begin
                if (bus.start) begin
                    state_d = SYNC;
                    sh_d    = SYNC_WORD;
                    dout_d  = SYNC_WORD[15];
                    div_d   = 4'd0;
                    cnt_d   = 11'd0;
                    und_d   = 1'b0;
                    hok_d   = 1'b0;
                    req_d   = 1'b0;
`ifdef K005297_BUBBLE_TX_CRC_EN
                    crc_d   = 16'hFFFF;
`endif
                end
            end else begin
                div_d = wrap ? 4'd0 : div + 4'd1;
                if (wrap) begin
                    cnt_d  = last ? 11'd0 : cnt + 11'd1;
                    sh_d   = {sh[14:0], 1'b0};
                    dout_d = sh[14];
                    case (state)
                        SYNC: begin
                            if (cnt == 11'd14) req_d = 1'b1;
                            if (last) state_d = DATA;
                        end
                        DATA: begin
                            if (cnt[2:0] == 3'd6 && cnt < 11'(DATA_BITS - 8)) req_d = 1'b1;
`ifdef K005297_BUBBLE_TX_CRC_EN
                            crc_d = crc_n;
                            if (last) begin
                                state_d = CRC;
                                sh_d    = crc_n;
                                dout_d  = crc_n[15];
                            end
                        end
                        CRC: begin
                            if (last) begin
                                state_d = GAP;
                                dout_d  = 1'b0;
                            end
`else
                            if (last) begin
                                state_d = GAP;
                                dout_d  = 1'b0;
                            end
`endif
                        end
                        default: begin
                            dout_d = 1'b0;
                            if (last) begin
                                state_d = IDLE;
                                fin_d   = 1'b1;
                            end
                        end
                    endcase
                    // a missing byte still occupies its slot, sent as zeros
                    if (load) begin
                        sh_d   = {nb, 8'h00};
                        dout_d = nb[7];
                        und_d  = und | ~(take | hok);
                        hok_d  = 1'b0;
                        req_d  = 1'b0;
                    end
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            div   <= 4'd0;
            cnt   <= 11'd0;
            sh    <= 16'h0000;
            hold  <= 8'h00;
            hok   <= 1'b0;
            req   <= 1'b0;
            dout  <= 1'b0;
            fin   <= 1'b0;
            und   <= 1'b0;
`ifdef K005297_BUBBLE_TX_CRC_EN
            crc   <= 16'hFFFF;
`endif
        end else begin
            state <= state_d;
            div   <= div_d;
            cnt   <= cnt_d;
            sh    <= sh_d;
            hold  <= hold_d;
            hok   <= hok_d;
            req   <= req_d;
            dout  <= dout_d;
            fin   <= fin_d;
            und   <= und_d;
`ifdef K005297_BUBBLE_TX_CRC_EN
            crc   <= crc_d;
`endif
        end
    end
endmodule

// File: tb/tb_k005297_bubble_page_tx.sv
// tb_k005297_bubble_page_tx: directed frames on a BIT_DIV=1 instance and a paced BIT_DIV=4 instance.
`timescale 1ns/1ps
module tb_k005297_bubble_page_tx;
    localparam int PB = 9;
`ifdef K005297_BUBBLE_TX_CRC_EN
    localparam int FL = 16 + 8 * PB + 16 + 8;
`else
    localparam int FL = 16 + 8 * PB + 8;
`endif
    logic clk = 1'b0;
    logic rst_n;
    int   pass_cnt = 0;
    int   total = 0;
    bit   drop = 1'b0;
    int   ptr = 0;
    bit   seen = 1'b0;

    k005297_bubble_page_tx_if b1();
    k005297_bubble_page_tx_if b4();

    k005297_bubble_page_tx #(.PAGE_BYTES(PB), .BIT_DIV(1), .SYNC_WORD(16'hF0A5), .GAP_BITS(8))
        u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    k005297_bubble_page_tx #(.PAGE_BYTES(PB), .BIT_DIV(4), .SYNC_WORD(16'hF0A5), .GAP_BITS(8))
        u4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    always #5 clk = ~clk;

    // byte source for u1: presents "123456789", advances when a request is retired
    always @(negedge clk) begin
        if (!b1.busy) begin
            ptr  = 0;
            seen = 1'b0;
        end else if (b1.breq) begin
            seen = 1'b1;
        end else if (seen) begin
            ptr++;
            seen = 1'b0;
        end
        b1.bvalid = !(drop && ptr == 3);
        b1.bdata  = 8'(49 + ptr);
    end

`ifdef K005297_BUBBLE_TX_CRC_EN
    function automatic logic [15:0] crc16(input logic [8*PB-1:0] d);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 8 * PB - 1; i >= 0; i--)
            c = (c[15] ^ d[i]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        return c;
    endfunction
`endif

    function automatic logic [FL-1:0] exp_stream(input bit dr);
        logic [8*PB-1:0] d;
        for (int k = 0; k < PB; k++) d[8*PB-1-8*k -: 8] = (dr && k == 3) ? 8'h00 : 8'(49 + k);
`ifdef K005297_BUBBLE_TX_CRC_EN
        return {16'hF0A5, d, dr ? crc16(d) : 16'h29B1, 8'h00};
`else
        return {16'hF0A5, d, 8'h00};
`endif
    endfunction

    task automatic capture(input bit pre, input int restart_at, input bit hold_end,
                           output logic [FL-1:0] s, output int early, output bit d_end,
                           output bit bz_end, output bit u_first, output bit u_end);
        early = 0;
        if (!pre) begin
            @(negedge clk);
            b1.start = 1'b1;
        end
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            b1.start = (i == restart_at) || (hold_end && i == FL - 1);
            s[FL-1-i] = b1.bdout;
            if (i == 0) u_first = b1.underrun;
            if (b1.done) early++;
        end
        @(negedge clk);
        d_end  = b1.done;
        bz_end = b1.busy;
        u_end  = b1.underrun;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({b1.breq, b1.bdout, b1.busy, b1.done, b1.underrun} !== 5'b0)
            $display("FAIL reset_u1 got %b want 00000", {b1.breq, b1.bdout, b1.busy, b1.done, b1.underrun});
        else pass_cnt++;
        total++;
        if ({b4.breq, b4.bdout, b4.busy, b4.done, b4.underrun} !== 5'b0)
            $display("FAIL reset_u4 got %b want 00000", {b4.breq, b4.bdout, b4.busy, b4.done, b4.underrun});
        else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [FL-1:0] s;
        int early;
        bit d, bz, uf, ue;
        drop = 1'b0;
        capture(1'b0, -1, 1'b0, s, early, d, bz, uf, ue);
        total++;
        if (s[FL-1 -: 16] !== 16'hF0A5) $display("FAIL basic_sync got %h want f0a5", s[FL-1 -: 16]);
        else pass_cnt++;
        for (int k = 0; k < PB; k++) begin
            total++;
            if (s[FL-17-8*k -: 8] !== 8'(49 + k))
                $display("FAIL basic_byte%0d got %h want %h", k, s[FL-17-8*k -: 8], 8'(49 + k));
            else pass_cnt++;
        end
`ifdef K005297_BUBBLE_TX_CRC_EN
        total++;
        if (s[23:8] !== 16'h29B1) $display("FAIL basic_crc got %h want 29b1", s[23:8]);
        else pass_cnt++;
`endif
        total++;
        if (s[7:0] !== 8'h00) $display("FAIL basic_gap got %h want 00", s[7:0]);
        else pass_cnt++;
        total++;
        if (early !== 0 || d !== 1'b1 || bz !== 1'b0)
            $display("FAIL basic_done early=%0d done=%b busy=%b want 0/1/0", early, d, bz);
        else pass_cnt++;
        total++;
        if (ue !== 1'b0) $display("FAIL basic_underrun got %b want 0", ue);
        else pass_cnt++;
    endtask

    task automatic test_pacing();
        logic [23:0] e;
        bit bad;
        logic got;
        int c, n;
        e = {16'hF0A5, 8'h3C};
        @(negedge clk);
        b4.cen_n = 1'b0;
        b4.start = 1'b1;
        for (int k = 0; k < 24; k++) begin
            bad = 1'b0;
            got = e[23-k];
            for (int j = 1; j <= 12; j++) begin
                @(negedge clk);
                c = 12 * k + j;
                b4.start = 1'b0;
                b4.cen_n = (c % 3) != 0;
                if (b4.bdout !== e[23-k]) begin
                    bad = 1'b1;
                    got = b4.bdout;
                end
            end
            total++;
            if (bad) $display("FAIL pace_bit%0d got %b want %b for 12 clocks", k, got, e[23-k]);
            else pass_cnt++;
        end
        b4.cen_n = 1'b0;
        n = 0;
        while (b4.done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (b4.done !== 1'b1) $display("FAIL pace_done got %b want 1 within 2000 clocks", b4.done);
        else pass_cnt++;
        total++;
        if (b4.underrun !== 1'b0) $display("FAIL pace_underrun got %b want 0", b4.underrun);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if ({b4.busy, b4.done, b4.bdout} !== 3'b000)
            $display("FAIL pace_idle got %b want 000", {b4.busy, b4.done, b4.bdout});
        else pass_cnt++;
    endtask

    task automatic test_underrun();
        logic [FL-1:0] s, e;
        int early;
        bit d, bz, uf, ue;
        drop = 1'b1;
        capture(1'b0, -1, 1'b0, s, early, d, bz, uf, ue);
        drop = 1'b0;
        e = exp_stream(1'b1);
        total++;
        if (s[FL-41 -: 8] !== 8'h00) $display("FAIL under_byte3 got %h want 00", s[FL-41 -: 8]);
        else pass_cnt++;
`ifdef K005297_BUBBLE_TX_CRC_EN
        total++;
        if (s[23:8] !== e[23:8]) $display("FAIL under_crc got %h want %h", s[23:8], e[23:8]);
        else pass_cnt++;
`endif
        total++;
        if (s !== e) $display("FAIL under_stream got %h want %h", s, e);
        else pass_cnt++;
        total++;
        if (early !== 0 || d !== 1'b1) $display("FAIL under_len early=%0d done=%b want 0/1", early, d);
        else pass_cnt++;
        total++;
        if (ue !== 1'b1) $display("FAIL under_flag got %b want 1", ue);
        else pass_cnt++;
        repeat (5) @(negedge clk);
        total++;
        if (b1.underrun !== 1'b1) $display("FAIL under_sticky got %b want 1", b1.underrun);
        else pass_cnt++;
    endtask

    task automatic test_start();
        logic [FL-1:0] s, e;
        int early;
        bit d, bz, uf, ue;
        e = exp_stream(1'b0);
        capture(1'b0, 40, 1'b1, s, early, d, bz, uf, ue);
        total++;
        if (uf !== 1'b0) $display("FAIL start_clear_underrun got %b want 0", uf);
        else pass_cnt++;
        total++;
        if (s !== e) $display("FAIL start_ignored_in_data got %h want %h", s, e);
        else pass_cnt++;
        total++;
        if (early !== 0 || d !== 1'b1 || bz !== 1'b0)
            $display("FAIL start_at_done early=%0d done=%b busy=%b want 0/1/0", early, d, bz);
        else pass_cnt++;
        capture(1'b1, -1, 1'b0, s, early, d, bz, uf, ue);
        total++;
        if (s !== e) $display("FAIL start_next_tick got %h want %h", s, e);
        else pass_cnt++;
        total++;
        if (early !== 0 || d !== 1'b1) $display("FAIL start_next_done early=%0d done=%b want 0/1", early, d);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [FL-1:0] s, e;
        int early;
        bit d, bz, uf, ue;
        e = exp_stream(1'b0);
        @(negedge clk);
        b1.start = 1'b1;
        @(negedge clk);
        b1.start = 1'b0;
        repeat (40) @(negedge clk);
        total++;
        if (b1.busy !== 1'b1) $display("FAIL rmid_busy_before got %b want 1", b1.busy);
        else pass_cnt++;
        rst_n    = 1'b0;
        b1.cen_n = 1'b1;
        @(negedge clk);
        total++;
        if ({b1.breq, b1.bdout, b1.busy, b1.done, b1.underrun} !== 5'b0)
            $display("FAIL rmid_outputs got %b want 00000", {b1.breq, b1.bdout, b1.busy, b1.done, b1.underrun});
        else pass_cnt++;
        rst_n    = 1'b1;
        b1.cen_n = 1'b0;
        capture(1'b0, -1, 1'b0, s, early, d, bz, uf, ue);
        total++;
        if (s !== e) $display("FAIL rmid_stream got %h want %h", s, e);
        else pass_cnt++;
        total++;
        if (early !== 0 || d !== 1'b1) $display("FAIL rmid_done early=%0d done=%b want 0/1", early, d);
        else pass_cnt++;
    endtask

    initial begin
        rst_n     = 1'b0;
        b1.cen_n  = 1'b0;
        b1.start  = 1'b0;
        b4.cen_n  = 1'b0;
        b4.start  = 1'b0;
        b4.bvalid = 1'b1;
        b4.bdata  = 8'h3C;
        test_reset();
        test_basic();
        test_pacing();
        test_underrun();
        test_start();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
